mips_hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding-select unit for the pipelined MIPS core. It replaces the fixed EXE/MEM/WB compare-and-stall hazard logic with an in-flight destination scoreboard of configurable depth and per-class result latency. The ID stage queries it for two source operands each cycle. It returns a stall request plus per-operand forwarding selects for the datapath muxes, and keeps a saturating stall-cycle performance counter.

---
 rtl/mips_hazard_scoreboard.sv | 129 ++++++++++++
 tb/tb_mips_hazard_scoreboard.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_scoreboard.sv
// +--------------------------------------------------------------------------+
// | mips_hazard_scoreboard: in-flight destination scoreboard that produces   |
// | the ID-stage stall request, operand forward selects and a stall counter. |
// | Optional macro HAZARD_FWD_EN enables forwarding from ready slots.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mips_hazard_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int LAT_STAGES = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [ADDR_W-1:0] id_wraddr,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [LAT_STAGES:1]             valid_q, valid_d;
  logic [LAT_STAGES:1][ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_STAGES:1]             load_q, load_d;
  logic [CNT_W-1:0]                stall_cnt_q, stall_cnt_d;

  logic [1:0][ADDR_W-1:0] op_addr;
  logic [1:0]             op_use;
  logic [1:0]             op_blk;
  logic [1:0][SEL_W-1:0]  op_fwd;

  assign op_addr[0] = id_rs;
  assign op_addr[1] = id_rt;
  assign op_use[0]  = id_use_rs;
  assign op_use[1]  = id_use_rt;

  for (genvar i = 0; i < 2; i++) begin : g_opnd
    logic             hit;
    logic             rdy;
    logic [SEL_W-1:0] sel;

    // Scan oldest to youngest so the youngest matching slot wins.
    always_comb begin
      hit = 1'b0;
      rdy = 1'b0;
      sel = '0;
      for (int k = LAT_STAGES; k >= 1; k--) begin
        if (valid_q[k] && (addr_q[k] == op_addr[i])) begin
          hit = 1'b1;
          sel = SEL_W'(k);
`ifdef HAZARD_FWD_EN
          rdy = (k >= (load_q[k] ? LOAD_READY : ALU_READY));
`else
          rdy = 1'b0;
`endif
        end
      end
      if (!op_use[i] || (op_addr[i] == '0)) begin
        hit = 1'b0;
      end
    end

    assign op_blk[i] = hit && !rdy;
    assign op_fwd[i] = (hit && rdy) ? sel : '0;
  end

`ifndef HAZARD_FWD_EN
  logic unused_load;
  assign unused_load = ^load_q;
`endif

  assign stall     = |op_blk;
  assign fwd_a     = stall ? '0 : op_fwd[0];
  assign fwd_b     = stall ? '0 : op_fwd[1];
  assign stall_cnt = stall_cnt_q;

  // Older slots advance every cycle; only slot 1 sees stall/flush bubbles.
  always_comb begin
    valid_d    = '0;
    addr_d     = addr_q;
    load_d     = load_q;
    valid_d[1] = !stall && !flush && id_wr_en && (id_wraddr != '0);
    addr_d[1]  = id_wraddr;
    load_d[1]  = id_is_load;
    for (int k = 2; k <= LAT_STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      addr_d[k]  = addr_q[k-1];
      load_d[k]  = load_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q     <= '0;
      addr_q      <= '0;
      load_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      load_q      <= load_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_hazard_scoreboard.sv
// +--------------------------------------------------------------------------+
// | tb_mips_hazard_scoreboard: directed self-checking bench for the hazard   |
// | scoreboard; expectations follow HAZARD_FWD_EN when it is defined.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mips_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  // Narrow counter keeps the saturation check short.
  localparam int CNT_W = 6;

  logic             clk;
  logic             nrst;
  logic [4:0]       id_rs, id_rt, id_wraddr;
  logic             id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic             flush, cnt_clr;
  logic             stall;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mips_hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_wraddr (id_wraddr),
    .id_wr_en  (id_wr_en),
    .id_is_load(id_is_load),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .stall     (stall),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic [4:0] wa, input logic we,
                     input logic ld, input logic fl);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wraddr = wa; id_wr_en = we; id_is_load = ld; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    cnt_clr = 1'b0;
    drv(5, 0, 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_cnt", stall_cnt, 0);
    nrst = 1'b1;
    #1;
    chk("empty_stall", stall, 0);
    chk("empty_fwd_a", fwd_a, 0);
    chk("empty_cnt", stall_cnt, 0);

    // ALU producer r8 followed directly by a consumer of r8 as rs.
    drv(0, 0, 0, 0, 8, 1, 0, 0);
    #1 chk("alu_prod_nostall", stall, 0);
    tick();
    drv(8, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < (FWD ? 1 : 3); i++) begin
      #1;
      chk("alu_stall", stall, 1);
      chk("alu_fwd_hold", fwd_a, 0);
      tick();
    end
    #1;
    chk("alu_release", stall, 0);
    chk("alu_fwd_a", fwd_a, FWD ? 2 : 0);
    chk("alu_cnt", stall_cnt, FWD ? 1 : 3);
    idle(3);

    // Load r9 followed by a consumer of r9 as rt.
    clr_cnt();
    #1 chk("clr_idle", stall_cnt, 0);
    drv(0, 0, 0, 0, 9, 1, 1, 0);
    tick();
    drv(0, 9, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < (FWD ? 2 : 3); i++) begin
      #1;
      chk("ld_stall", stall, 1);
      chk("ld_fwd_hold", fwd_b, 0);
      tick();
    end
    #1;
    chk("ld_release", stall, 0);
    chk("ld_fwd_b", fwd_b, FWD ? 3 : 0);
    chk("ld_cnt", stall_cnt, FWD ? 2 : 3);
    idle(3);

    // Two writers of r4; the younger one in slot 1 decides.
    clr_cnt();
    drv(0, 0, 0, 0, 4, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0, 4, 1, 0, 0);
    tick();
    drv(4, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < (FWD ? 1 : 3); i++) begin
      #1;
      chk("young_stall", stall, 1);
      tick();
    end
    #1;
    chk("young_release", stall, 0);
    chk("young_fwd_a", fwd_a, FWD ? 2 : 0);
    chk("young_cnt", stall_cnt, FWD ? 1 : 3);
    idle(3);

    // Both operands hit different slots at once.
    clr_cnt();
    drv(0, 0, 0, 0, 10, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0, 11, 1, 0, 0);
    tick();
    idle(1);
    drv(10, 11, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < (FWD ? 0 : 2); i++) begin
      #1;
      chk("dual_stall", stall, 1);
      tick();
    end
    #1;
    chk("dual_release", stall, 0);
    chk("dual_fwd_a", fwd_a, FWD ? 3 : 0);
    chk("dual_fwd_b", fwd_b, FWD ? 2 : 0);
    chk("dual_cnt", stall_cnt, FWD ? 0 : 2);
    idle(3);

    // Writes that must never create hazards.
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drv(0, 0, 1, 1, 0, 0, 0, 0);
    #1 chk("r0_stall", stall, 0);
    drv(0, 0, 0, 0, 7, 1, 0, 1);
    tick();
    drv(7, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("flush_stall", stall, 0);
    chk("flush_fwd_a", fwd_a, 0);
    drv(0, 0, 0, 0, 6, 0, 0, 0);
    tick();
    drv(0, 6, 0, 1, 0, 0, 0, 0);
    #1 chk("nowr_stall", stall, 0);
    drv(0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    drv(5, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("nouse_stall", stall, 0);
    idle(3);

    // Reset while a hazard is pending discards the entry at once.
    drv(0, 0, 0, 0, 12, 1, 0, 0);
    tick();
    drv(12, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("mid_pre_stall", stall, 1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_cnt", stall_cnt, 0);
    tick();
    nrst = 1'b1;
    #1 chk("mid_post_stall", stall, 0);
    idle(3);

    // Saturation: a self-dependent load chain stalls most cycles.
    clr_cnt();
    drv(1, 0, 1, 0, 1, 1, 1, 0);
    for (int g = 0; g < 300; g++) begin
      #1;
      if (stall_cnt == 6'd62) break;
      tick();
    end
    chk("sat_reach", stall_cnt, 62);
    repeat (8) tick();
    #1 chk("sat_max", stall_cnt, 63);
    repeat (4) tick();
    #1 chk("sat_hold", stall_cnt, 63);
    for (int g = 0; g < 10; g++) begin
      #1;
      if (stall) break;
      tick();
    end
    chk("clr_stall_seen", stall, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1 chk("clr_wins", stall_cnt, 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
